// File: rtl/game_pkg.sv
// Shared types for the game state unit: game/scan state encodings and default tile width.
package game_pkg;

  localparam int POS_W_DEF = 8;

  // G_PLAY: hits cost a life | G_INVULN: post-hit grace frames | G_OVER: no lives left
  typedef enum logic [1:0] {G_PLAY, G_INVULN, G_OVER} game_state_t;

  // S_IDLE: waiting for frame_start | S_SCAN: one segment per cycle | S_RESOLVE: publish results
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESOLVE} scan_state_t;

endpackage

// File: rtl/pos_match.sv
// Combinational per-segment comparator against the player and sword tiles.
module pos_match
  import game_pkg::*;
#(
  parameter int POS_W = POS_W_DEF
) (
  input  logic [POS_W-1:0] seg_pos,
  input  logic             seg_valid,
  input  logic [POS_W-1:0] player_pos,
  input  logic [POS_W-1:0] sword_pos,
  input  logic             sword_active,
  output logic             player_match,
  output logic             sword_match
);

  assign player_match = seg_valid && (seg_pos == player_pos);
  assign sword_match  = seg_valid && sword_active && (seg_pos == sword_pos);

endmodule

// File: rtl/game_state_unit.sv
// Per-frame collision scan of the dragon segments plus lives/invulnerability bookkeeping.
// One shared comparator walks the snapshot; results are published together at RESOLVE.
module game_state_unit
  import game_pkg::*;
#(
  parameter int NUM_SEGMENTS  = 7,
  parameter int POS_W         = POS_W_DEF,
  parameter int LIVES_W       = 2,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          restart,
  input  logic [POS_W-1:0]              player_pos,
  input  logic [POS_W-1:0]              sword_pos,
  input  logic                          sword_active,
  input  logic [NUM_SEGMENTS*POS_W-1:0] seg_pos,
  input  logic [NUM_SEGMENTS-1:0]       seg_valid,
  output logic [LIVES_W-1:0]            lives,
  output logic                          collision,
  output logic                          player_hit,
  output logic [NUM_SEGMENTS-1:0]       seg_hit,
  output logic                          game_over,
  output logic                          invulnerable,
  output logic                          scan_busy
);

  localparam int IDX_W = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);

  scan_state_t scan_state, scan_next;
  game_state_t game_state, game_next;

  logic [IDX_W-1:0]              idx;
  logic [POS_W-1:0]              snap_player, snap_sword;
  logic                          snap_active;
  logic [NUM_SEGMENTS*POS_W-1:0] snap_seg;
  logic [NUM_SEGMENTS-1:0]       snap_valid;
  logic                          acc_player;
  logic [NUM_SEGMENTS-1:0]       acc_sword;
  logic [CNT_W-1:0]              frame_cnt, cnt_next;
  logic [LIVES_W-1:0]            lives_next;
  logic                          hit_next;
  logic                          accept, resolve;
  logic                          player_match, sword_match;
  logic [POS_W-1:0]              cur_seg;

  assign accept  = (scan_state == S_IDLE) && frame_start && !restart;
  assign resolve = (scan_state == S_RESOLVE);
  assign cur_seg = snap_seg[int'(idx)*POS_W +: POS_W];

  pos_match #(.POS_W(POS_W)) u_pos_match (
    .seg_pos      (cur_seg),
    .seg_valid    (snap_valid[idx]),
    .player_pos   (snap_player),
    .sword_pos    (snap_sword),
    .sword_active (snap_active),
    .player_match (player_match),
    .sword_match  (sword_match)
  );

  always_comb begin
    scan_next = scan_state;
    case (scan_state)
      S_IDLE:    if (frame_start) scan_next = S_SCAN;
      S_SCAN:    if (idx == IDX_W'(NUM_SEGMENTS - 1)) scan_next = S_RESOLVE;
      S_RESOLVE: scan_next = S_IDLE;
      default:   scan_next = S_IDLE;
    endcase
    if (restart) scan_next = S_IDLE;
  end

  always_comb begin
    game_next  = game_state;
    lives_next = lives;
    cnt_next   = frame_cnt;
    hit_next   = 1'b0;
    case (game_state)
      G_PLAY: begin
        if (resolve && acc_player) begin
          hit_next   = 1'b1;
          lives_next = (lives != '0) ? lives - LIVES_W'(1) : '0;
          if (lives <= LIVES_W'(1)) begin
            game_next = G_OVER;
          end else begin
            game_next = G_INVULN;
            cnt_next  = CNT_W'(INVULN_FRAMES);
          end
        end
      end
      G_INVULN: begin
        if (accept && frame_cnt != '0) begin
          cnt_next = frame_cnt - CNT_W'(1);
          if (frame_cnt == CNT_W'(1)) game_next = G_PLAY;
        end
      end
      G_OVER:  lives_next = '0;
      default: game_next = G_PLAY;
    endcase
    if (restart) begin
      game_next  = G_PLAY;
      lives_next = LIVES_W'(START_LIVES);
      cnt_next   = '0;
      hit_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_state <= S_IDLE;
      game_state <= G_PLAY;
      lives      <= LIVES_W'(START_LIVES);
      frame_cnt  <= '0;
      player_hit <= 1'b0;
    end else begin
      scan_state <= scan_next;
      game_state <= game_next;
      lives      <= lives_next;
      frame_cnt  <= cnt_next;
      player_hit <= hit_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      idx         <= '0;
      acc_player  <= 1'b0;
      acc_sword   <= '0;
      collision   <= 1'b0;
      seg_hit     <= '0;
      snap_player <= '0;
      snap_sword  <= '0;
      snap_active <= 1'b0;
      snap_seg    <= '0;
      snap_valid  <= '0;
    end else if (accept) begin
      idx         <= '0;
      acc_player  <= 1'b0;
      acc_sword   <= '0;
      snap_player <= player_pos;
      snap_sword  <= sword_pos;
      snap_active <= sword_active;
      snap_seg    <= seg_pos;
      snap_valid  <= seg_valid;
    end else if (scan_state == S_SCAN) begin
      acc_player     <= acc_player | player_match;
      acc_sword[idx] <= sword_match;
      idx            <= idx + IDX_W'(1);
    end else if (resolve) begin
      collision <= acc_player;
      seg_hit   <= acc_sword;
    end
  end

  assign scan_busy    = (scan_state != S_IDLE);
  assign game_over    = (game_state == G_OVER);
  assign invulnerable = (game_state == G_INVULN);

endmodule
